layer_compositor_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational priority plane mux at the video top level.
- Merges PLANES colour planes (plane 0 lowest priority, PLANES-1 highest) into one pixel stream for the VGA output block.
- Per-plane enable and transparent key are runtime-programmable, staged in shadow registers and committed only at frame start so mid-frame writes do not tear.
- Sits between the sprite/BG plane outputs and the VGA colour input, in the video clock domain.

---
 rtl/layer_compositor_pipe.sv | 164 ++++++++++++++++
 tb/tb_layer_compositor_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : layer_compositor_pipe
// Brief    : PLANES-stage priority compositor with frame-synchronous shadow
//            config (enable + transparent key per plane). Optional per-plane
//            byte-average blending when LAYER_COMPOSITOR_BLEND_EN is defined.
// Revision : 1.0
// ============================================================================
module layer_compositor_pipe #(
    parameter int                     PLANES      = 9,
    parameter int                     COLOR_WIDTH = 32,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR    = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [PLANES*COLOR_WIDTH-1:0]   color_in,
    input  logic                            de_in,
    input  logic                            frame_start,
    input  logic                            cfg_we,
    input  logic [$clog2(PLANES)-1:0]       cfg_plane,
    input  logic                            cfg_enable,
`ifdef LAYER_COMPOSITOR_BLEND_EN
    input  logic                            cfg_blend,
`endif
    input  logic [COLOR_WIDTH-1:0]          cfg_key,
    output logic [COLOR_WIDTH-1:0]          color_out,
    output logic                            de_out,
    output logic [$clog2(PLANES+1)-1:0]     hit_plane
);

    localparam int             HW     = $clog2(PLANES + 1);
    localparam logic [HW-1:0]  HIT_BG = HW'(PLANES);

    logic [PLANES-1:0]      sh_en_q;
    logic [PLANES-1:0]      act_en_q;
    logic [COLOR_WIDTH-1:0] sh_key_q  [PLANES];
    logic [COLOR_WIDTH-1:0] act_key_q [PLANES];
    logic                   cfg_wr;

    assign cfg_wr = cfg_we && (int'(cfg_plane) < PLANES);

    // Commit reads the shadow before this edge's write lands, so a write in
    // the commit cycle waits for the following frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_en_q  <= '1;
            act_en_q <= '1;
            for (int i = 0; i < PLANES; i++) begin
                sh_key_q[i]  <= '0;
                act_key_q[i] <= '0;
            end
        end else begin
            if (cfg_wr) begin
                sh_en_q[cfg_plane]  <= cfg_enable;
                sh_key_q[cfg_plane] <= cfg_key;
            end
            if (frame_start) begin
                act_en_q  <= sh_en_q;
                act_key_q <= sh_key_q;
            end
        end
    end

`ifdef LAYER_COMPOSITOR_BLEND_EN
    logic [PLANES-1:0] sh_blend_q;
    logic [PLANES-1:0] act_blend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_blend_q  <= '0;
            act_blend_q <= '0;
        end else begin
            if (cfg_wr) begin
                sh_blend_q[cfg_plane] <= cfg_blend;
            end
            if (frame_start) begin
                act_blend_q <= sh_blend_q;
            end
        end
    end

    function automatic logic [COLOR_WIDTH-1:0] avg_bytes(
        input logic [COLOR_WIDTH-1:0] a,
        input logic [COLOR_WIDTH-1:0] b
    );
        logic [COLOR_WIDTH-1:0] r;
        logic [8:0]             s;
        r = '0;
        for (int i = 0; i < COLOR_WIDTH / 8; i++) begin
            s           = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
            r[i*8 +: 8] = s[8:1];
        end
        return r;
    endfunction
`endif

    for (genvar k = 0; k < PLANES; k++) begin : g_stage
        logic [COLOR_WIDTH-1:0] pix;
        logic [COLOR_WIDTH-1:0] below_col;
        logic [HW-1:0]          below_hit;
        logic                   below_de;
        logic                   opaque;
        logic [COLOR_WIDTH-1:0] col_d;
        logic [HW-1:0]          hit_d;
        logic [COLOR_WIDTH-1:0] col_q;
        logic [HW-1:0]          hit_q;
        logic                   de_q;

        if (k == 0) begin : g_base
            assign pix       = color_in[COLOR_WIDTH-1:0];
            assign below_col = BG_COLOR;
            assign below_hit = HIT_BG;
            assign below_de  = de_in;
        end else begin : g_skew
            // k-deep delay line aligns plane k with the pixel reaching stage k.
            logic [COLOR_WIDTH-1:0] dly_q [k];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int j = 0; j < k; j++) begin
                        dly_q[j] <= '0;
                    end
                end else begin
                    dly_q[0] <= color_in[k*COLOR_WIDTH +: COLOR_WIDTH];
                    for (int j = 1; j < k; j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                end
            end

            assign pix       = dly_q[k-1];
            assign below_col = g_stage[k-1].col_q;
            assign below_hit = g_stage[k-1].hit_q;
            assign below_de  = g_stage[k-1].de_q;
        end

        assign opaque = act_en_q[k] && (pix != act_key_q[k]);
`ifdef LAYER_COMPOSITOR_BLEND_EN
        assign col_d  = !opaque ? below_col
                      : (act_blend_q[k] ? avg_bytes(pix, below_col) : pix);
`else
        assign col_d  = opaque ? pix : below_col;
`endif
        assign hit_d  = opaque ? HW'(k) : below_hit;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                col_q <= '0;
                hit_q <= HIT_BG;
                de_q  <= 1'b0;
            end else begin
                col_q <= col_d;
                hit_q <= hit_d;
                de_q  <= below_de;
            end
        end
    end

    assign color_out = g_stage[PLANES-1].col_q;
    assign hit_plane = g_stage[PLANES-1].hit_q;
    assign de_out    = g_stage[PLANES-1].de_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_compositor_pipe
// Brief    : Scoreboard bench for layer_compositor_pipe (PLANES=9, 32-bit).
// Revision : 1.0
// ============================================================================
module tb_layer_compositor_pipe;

    localparam int P  = 9;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [P*CW-1:0]   color_in;
    logic              de_in;
    logic              frame_start;
    logic              cfg_we;
    logic [3:0]        cfg_plane;
    logic              cfg_enable;
    logic              cfg_blend;
    logic [CW-1:0]     cfg_key;
    logic [CW-1:0]     color_out;
    logic              de_out;
    logic [3:0]        hit_plane;

    typedef struct {
        logic [31:0] col;
        logic [3:0]  hit;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pix [P];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    layer_compositor_pipe #(
        .PLANES      (P),
        .COLOR_WIDTH (CW),
        .BG_COLOR    ('0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .color_in    (color_in),
        .de_in       (de_in),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_plane   (cfg_plane),
        .cfg_enable  (cfg_enable),
`ifdef LAYER_COMPOSITOR_BLEND_EN
        .cfg_blend   (cfg_blend),
`endif
        .cfg_key     (cfg_key),
        .color_out   (color_out),
        .de_out      (de_out),
        .hit_plane   (hit_plane)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && de_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_de_out: got de_out=1 color=%h, required no output", color_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("color", color_out, e.col);
                chk("hit_plane", 32'(hit_plane), 32'(e.hit));
                chk("latency", 32'(cyc - e.cyc), 32'd9);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input logic [31:0] ec, input logic [3:0] eh);
        exp_t e;
        tick();
        for (int k = 0; k < P; k++) color_in[k*CW +: CW] = pix[k];
        de_in = 1'b1;
        e.col = ec;
        e.hit = eh;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            de_in = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] ec, input logic [3:0] eh);
        drive_px(ec, eh);
        idle(12);
    endtask

    task automatic cfg(input int plane, input logic en, input logic [31:0] key, input logic bl);
        tick();
        cfg_we     = 1'b1;
        cfg_plane  = 4'(plane);
        cfg_enable = en;
        cfg_key    = key;
        cfg_blend  = bl;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic commit();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic cfg_commit(input int plane, input logic en, input logic [31:0] key);
        tick();
        cfg_we      = 1'b1;
        frame_start = 1'b1;
        cfg_plane   = 4'(plane);
        cfg_enable  = en;
        cfg_key     = key;
        cfg_blend   = 1'b0;
        tick();
        cfg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        color_in    = '0;
        de_in       = 1'b0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        cfg_plane   = '0;
        cfg_enable  = 1'b0;
        cfg_blend   = 1'b0;
        cfg_key     = '0;
        for (int k = 0; k < P; k++) pix[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_color", color_out, 32'h0);
        chk("reset_de", 32'(de_out), 32'h0);
        chk("reset_hit", 32'(hit_plane), 32'd9);
        reset_n = 1'b1;
        idle(2);

        // Defaults: key 0 transparent, only plane 0 shows.
        pix[0] = 32'h0011_2233;
        send(32'h0011_2233, 4'd0);

        pix[3] = 32'h0000_00FF;
        pix[7] = 32'h0000_FF00;
        send(32'h0000_FF00, 4'd7);

        cfg(7, 1'b0, 32'h0, 1'b0);
        commit();
        send(32'h0000_00FF, 4'd3);

        cfg(7, 1'b1, 32'h0, 1'b0);
        commit();
        send(32'h0000_FF00, 4'd7);

        // Staged key has no effect until the next commit.
        cfg(7, 1'b1, 32'h0000_FF00, 1'b0);
        send(32'h0000_FF00, 4'd7);
        commit();
        send(32'h0000_00FF, 4'd3);

        pix[0] = 32'h0;
        cfg_commit(3, 1'b0, 32'h0);
        send(32'h0000_00FF, 4'd3);
        commit();
        send(32'h0, 4'd9);

        // Out-of-range plane writes must be ignored.
        pix[1] = 32'h0000_0055;
        send(32'h0000_0055, 4'd1);
        cfg(9, 1'b0, 32'h0000_0055, 1'b0);
        cfg(15, 1'b0, 32'h0000_0055, 1'b0);
        commit();
        send(32'h0000_0055, 4'd1);

        // Back-to-back pixels.
        pix[1] = 32'h0000_0055;
        drive_px(32'h0000_0055, 4'd1);
        pix[1] = 32'h0;
        drive_px(32'h0, 4'd9);
        pix[1] = 32'h0000_0066;
        drive_px(32'h0000_0066, 4'd1);
        idle(12);

        // Asynchronous reset mid-stream drops the in-flight pixel.
        drive_px(32'h0000_0066, 4'd1);
        idle(3);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_color", color_out, 32'h0);
        chk("async_reset_de", 32'(de_out), 32'h0);
        chk("async_reset_hit", 32'(hit_plane), 32'd9);
        repeat (3) tick();
        reset_n = 1'b1;
        idle(12);

        // Config back to defaults: plane 7 key 0 again, so it wins.
        send(32'h0000_FF00, 4'd7);

`ifdef LAYER_COMPOSITOR_BLEND_EN
        for (int k = 0; k < P; k++) pix[k] = '0;
        pix[0] = 32'h00FF_0000;
        pix[1] = 32'h0001_FF00;
        cfg(1, 1'b1, 32'h0, 1'b1);
        commit();
        send(32'h0080_7F00, 4'd1);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
